// File: rtl/neo_frame_sender.sv
// Frame buffer for the WS2812 serializer: streams stored pixel words over AXIS,
// waits for the last word to shift out, holds the latch gap, then pulses done.
module neo_frame_sender #(
    parameter int MAX_PIXELS   = 64,
    parameter int ADDR_W       = 6,
    parameter int LATCH_CYCLES = 6600
) (
    input  logic              axis_aclk,
    input  logic              axis_resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   num_pixels,
    output logic              busy,
    output logic              done,
    output logic [31:0]       m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready
);
    localparam int CNT_W = $clog2(LATCH_CYCLES + 1);
    localparam logic [ADDR_W:0]  MAX_N      = (ADDR_W + 1)'(MAX_PIXELS);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PRESENT,
        S_DRAIN,
        S_LATCH,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       ram [MAX_PIXELS];
    logic [31:0]       rd_data;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   count_n;
    logic [ADDR_W:0]   n_clamped;
    logic [CNT_W-1:0]  counter;
    logic              xfer;
    logic              last_word;

    assign n_clamped = (num_pixels > MAX_N) ? MAX_N : num_pixels;
    assign xfer      = m_axis_valid & m_axis_ready;
    assign last_word = ({1'b0, index} == (count_n - (ADDR_W + 1)'(1)));

    // Read port tracks index every cycle; the word is taken in LOAD, so writes
    // landing before an index is fetched are still sent in the current frame.
    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
        rd_data <= ram[index];
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (start) state_next = (n_clamped == '0) ? S_DRAIN : S_FETCH;
            S_FETCH:   state_next = S_LOAD;
            S_LOAD:    state_next = S_PRESENT;
            S_PRESENT: if (xfer) state_next = last_word ? S_DRAIN : S_FETCH;
            S_DRAIN:   if (m_axis_ready) state_next = S_LATCH;
            S_LATCH:   if (counter == LATCH_LAST) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            m_axis_data  <= '0;
            m_axis_valid <= 1'b0;
            index        <= '0;
            count_n      <= '0;
            counter      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        count_n <= n_clamped;
                        index   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    m_axis_data  <= rd_data;
                    m_axis_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (xfer) begin
                        m_axis_valid <= 1'b0;
                        if (!last_word) begin
                            index <= index + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (m_axis_ready) begin
                        counter <= '0;
                    end
                end
                S_LATCH: begin
                    counter <= counter + CNT_W'(1);
                    if (counter == LATCH_LAST) begin
                        done <= 1'b1;
                    end
                end
                S_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neo_frame_sender.sv
// Bench for neo_frame_sender: frames checked against a shadow pixel memory and
// a cycle history of the serializer ready line.
module tb_neo_frame_sender;
    localparam int MAXP = 64;
    localparam int AW   = 6;
    localparam int LC   = 20;
    localparam int HN   = 65536;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [31:0]   wr_data    = '0;
    logic          start      = 1'b0;
    logic [AW:0]   num_pixels = '0;
    logic          busy;
    logic          done;
    logic [31:0]   data;
    logic          valid;
    logic          ready      = 1'b1;

    neo_frame_sender #(.MAX_PIXELS(MAXP), .ADDR_W(AW), .LATCH_CYCLES(LC)) dut (
        .axis_aclk    (clk),
        .axis_resetn  (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .num_pixels   (num_pixels),
        .busy         (busy),
        .done         (done),
        .m_axis_data  (data),
        .m_axis_valid (valid),
        .m_axis_ready (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [31:0] shadow [MAXP];
    logic [31:0] exp_q [$];

    // History sampled mid-cycle: index k holds values seen after edge k,
    // rdy_hist[k] holds ready as presented to edge k.
    bit          rdy_hist   [HN];
    bit          busy_hist  [HN];
    bit          valid_hist [HN];
    bit          done_hist  [HN];
    logic [31:0] data_hist  [HN];
    logic [31:0] got [$];
    int          got_edge [$];

    always @(negedge clk) begin
        rdy_hist[(cyc + 1) % HN] = ready;
        busy_hist[cyc % HN]      = (busy === 1'b1);
        valid_hist[cyc % HN]     = (valid === 1'b1);
        done_hist[cyc % HN]      = (done === 1'b1);
        data_hist[cyc % HN]      = data;
        if (valid === 1'b1 && ready === 1'b1) begin
            got.push_back(data);
            got_edge.push_back(cyc + 1);
        end
    end

    // Serializer model: drops ready for stall_len cycles after every word.
    int stall_len = 0;
    bit rand_rdy  = 1'b0;
    int seen      = 0;
    int hold      = 0;
    always @(posedge clk) begin
        #1;
        if (got.size() != seen) begin
            seen = got.size();
            hold = stall_len;
        end
        if (hold > 0) begin
            ready = 1'b0;
            hold--;
        end else if (rand_rdy) begin
            ready = 1'($urandom_range(1));
        end else begin
            ready = 1'b1;
        end
    end

    task automatic write_word(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        shadow[a] = d;
    endtask

    task automatic build_expected(input int n);
        int nn;
        nn = (n > MAXP) ? MAXP : n;
        exp_q.delete();
        for (int i = 0; i < nn; i++) exp_q.push_back(shadow[i]);
    endtask

    task automatic start_frame(input int n, output int e);
        @(posedge clk); #1;
        start = 1'b1; num_pixels = (AW + 1)'(n); e = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1; num_pixels = (AW + 1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit start_at_done, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            checks++; errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, budget);
        end else if (start_at_done) begin
            start = 1'b1; num_pixels = (AW + 1)'(2);
            @(posedge clk); #1;
            start = 1'b0;
        end
        #1;
    endtask

    task automatic wait_xfers(input string tag, input int target, input int budget);
        int t;
        t = 0;
        while (got.size() < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (got.size() < target) begin
            checks++; errors++;
            $display("FAIL %s xfer_timeout: got %0d transfers, needed %0d", tag, got.size(), target);
        end
    endtask

    task automatic check_frame(input string tag, input int e, input int base, input int dc);
        int n, gn, fv, l, d, bad_busy, bad_hold, dones;
        if (dc < 0) return;
        n  = exp_q.size();
        gn = got.size() - base;
        checks++;
        if (gn !== n) begin
            errors++;
            $display("FAIL %s count: got %0d transfers, expected %0d", tag, gn, n);
        end
        for (int i = 0; i < n && i < gn; i++) begin
            checks++;
            if (got[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word[%0d]: got %h expected %h", tag, i, got[base + i], exp_q[i]);
            end
        end
        if (n > 0) begin
            fv = -1;
            for (int k = e; k <= dc; k++) if (valid_hist[k % HN] && fv < 0) fv = k;
            checks++;
            if (fv !== e + 2) begin
                errors++;
                $display("FAIL %s first_valid: at edge %0d expected %0d", tag, fv, e + 2);
            end
        end
        l = (n > 0 && gn > 0) ? got_edge[base + gn - 1] : e;
        d = l + 1;
        while (d < dc && !rdy_hist[d % HN]) d++;
        checks++;
        if (dc !== d + LC) begin
            errors++;
            $display("FAIL %s done_time: done at %0d expected %0d", tag, dc, d + LC);
        end
        bad_busy = 0; bad_hold = 0; dones = 0;
        for (int k = e; k <= dc; k++) begin
            if (!busy_hist[k % HN]) bad_busy++;
            if (done_hist[k % HN]) dones++;
            if (k < dc && valid_hist[k % HN] && !rdy_hist[(k + 1) % HN] &&
                (!valid_hist[(k + 1) % HN] || data_hist[(k + 1) % HN] !== data_hist[k % HN]))
                bad_hold++;
        end
        checks++;
        if (bad_busy != 0 || dones != 1) begin
            errors++;
            $display("FAIL %s busy_done: busy-low cycles %0d done pulses %0d, expected 0 and 1", tag, bad_busy, dones);
        end
        checks++;
        if (bad_hold != 0) begin
            errors++;
            $display("FAIL %s stall_hold: %0d unstable stalled cycles, expected 0", tag, bad_hold);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: busy %b done %b, expected 0 0", tag, busy, done);
        end
    endtask

    task automatic run_frame(input string tag, input int n, input int budget, output int e, output int dc);
        int base;
        base = got.size();
        build_expected(n);
        start_frame(n, e);
        wait_done(tag, budget, 1'b0, dc);
        check_frame(tag, e, base, dc);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid %b busy %b done %b data %h, expected 0 0 0 0", valid, busy, done, data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int e, dc;
        write_word(0, 32'hFF000000);
        write_word(1, 32'h00FF0000);
        write_word(2, 32'h0000FF00);
        run_frame("basic", 3, 200, e, dc);
    endtask

    task automatic test_backpressure;
        int e, dc;
        write_word(0, $urandom);
        write_word(1, $urandom);
        stall_len = 800;
        run_frame("backpressure", 2, 3000, e, dc);
        stall_len = 0;
    endtask

    task automatic test_zero_clamp;
        int e, dc;
        run_frame("zero", 0, 100, e, dc);
        checks++;
        if (dc - e !== 21) begin
            errors++;
            $display("FAIL zero_latency: done %0d cycles after accept edge, expected 21", dc - e);
        end
        for (int i = 0; i < MAXP; i++) write_word(i, $urandom);
        run_frame("clamp", 100, 600, e, dc);
    endtask

    task automatic test_random;
        int e, dc;
        rand_rdy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 3; w++) write_word($urandom_range(11), $urandom);
            run_frame("random", $urandom_range(1, 12), 800, e, dc);
        end
        rand_rdy = 1'b0;
    endtask

    task automatic test_start_busy;
        int e, dc, base;
        stall_len = 10;
        base = got.size();
        build_expected(3);
        start_frame(3, e);
        wait_xfers("start_busy", base + 1, 100);
        pulse_start(5);
        wait_done("start_busy", 400, 1'b1, dc);
        check_frame("start_busy", e, base, dc);
        stall_len = 0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || got.size() - base !== 3) begin
            errors++;
            $display("FAIL ignored_start: busy %b valid %b transfers %0d, expected 0 0 3", busy, valid, got.size() - base);
        end
        run_frame("after_ignored", 2, 200, e, dc);
    endtask

    task automatic test_write_during;
        int e, dc, base;
        for (int i = 0; i < 4; i++) write_word(i, $urandom);
        stall_len = 40;
        base = got.size();
        build_expected(4);
        exp_q[3] = 32'hA5A5A5A5;
        start_frame(4, e);
        wait_xfers("write_during", base + 1, 100);
        repeat (5) @(negedge clk);
        write_word(3, 32'hA5A5A5A5);
        write_word(0, 32'h12345678);
        wait_done("write_during", 600, 1'b0, dc);
        check_frame("write_during", e, base, dc);
        stall_len = 0;
    endtask

    task automatic test_async_reset;
        int e, dc, base;
        stall_len = 50;
        base = got.size();
        start_frame(3, e);
        wait_xfers("async_reset", base + 1, 100);
        repeat (5) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: valid %b busy %b, expected 0 0", valid, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall_len = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid %b busy %b, expected 0 0", valid, busy);
        end
        run_frame("post_reset", 3, 300, e, dc);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_zero_clamp;
        test_random;
        test_start_busy;
        test_write_during;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
